lcd_char_scheduler: RTL and testbench
=====================================

# lcd_char_scheduler

Sequencing controller for the SHT30 LCD readout path. It paces the character selector one glyph at a time and hands each glyph's window to the LCD draw engine. It alternates temperature and humidity lines and waits a refresh gap between frames. It sits between the LCD init block, the character selector (`next_char_flag`/`select` out; `the_char`/`window_x0`/`x_size` in) and the draw engine (start/done handshake).

## Interface
Parameters:
- `Y_TEMP`, 16'd40: window y0 of the temperature line (`select`=1).
- `Y_HUM`, 16'd100: window y0 of the humidity line (`select`=0).
- `CHAR_H`, 16'd32: glyph height in rows; y1 = y0 + CHAR_H - 1.
- `GAP_CYC`, 32'd25_000_000: idle cycles between frames.
- `TIMEOUT_CYC`, 32'd1_000_000: maximum wait for `draw_done`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `init_done` in 1: LCD init complete (level).
- `the_char` in 7: one-hot current glyph from the selector; XIAOSHU = 7'b1000000.
- `window_x0` in 16: glyph x0 from the selector.
- `x_size` in 6: glyph width-1 from the selector. It is registered there, so it is valid 1 cycle after `the_char`.
- `draw_done` in 1: single-cycle pulse, draw engine finished a glyph.
- `next_char_flag` out 1: single-cycle advance pulse to the selector.
- `select` out 1: 1 = temperature line, 0 = humidity line.
- `draw_start` out 1: single-cycle pulse requesting a glyph draw.
- `win_x0`, `win_x1`, `win_y0`, `win_y1` out 16 each: window held stable from `draw_start` until the next `draw_start`.
- `frame_done` out 1: single-cycle pulse after the humidity line completes.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky; set on any draw timeout.

## Operation
- States: IDLE, SETTLE, START, WAIT, ADVANCE, GAP.
- **IDLE.** Wait for `init_done`=1, then go to SETTLE.
- **SETTLE.** Wait 2 cycles so the `the_char` update and the registered `x_size` both propagate.
  - If `init_done`=0 at any SETTLE cycle, go to IDLE.
  - Otherwise go to START.
- **START.** Register the window, pulse `draw_start` for 1 cycle, go to WAIT.
  - `win_x0` = `window_x0`.
  - `win_x1` = `window_x0` + `x_size` (16-bit, zero-extend `x_size`; wrap is not checked).
  - `win_y0` = `select` ? `Y_TEMP` : `Y_HUM`.
  - `win_y1` = `win_y0` + `CHAR_H` - 1.
- **WAIT.** Count cycles.
  - On `draw_done`, go to ADVANCE.
  - When the count reaches `TIMEOUT_CYC` with no `draw_done`, set `err_timeout` and go to ADVANCE anyway.
  - `draw_done` is sampled only in WAIT. A pulse in any other state, including the START cycle, is ignored.
- **ADVANCE.** Pulse `next_char_flag` for 1 cycle. Then:
  - If `the_char` ≠ XIAOSHU: go to SETTLE.
  - If `the_char` = XIAOSHU and `select`=1: `select` ← 0, go to SETTLE.
  - If `the_char` = XIAOSHU and `select`=0: `select` ← 1, pulse `frame_done`, go to GAP.
- **GAP.** Count `GAP_CYC` cycles, then go to SETTLE.
  - If `init_done`=0 during GAP, go to IDLE.
- Line length is decided by the selector's sign handling (7 glyphs on the first line after reset, then 4 or 5). The scheduler only detects the XIAOSHU terminator and never counts glyphs.
- `init_done` falling during WAIT does not abort the draw; it is acted on at the next SETTLE or GAP.

## Timing
- Reset values:
  - state = IDLE, `select`=1.
  - All window outputs = 0.
  - `next_char_flag`, `draw_start`, `frame_done`, `busy`, `err_timeout` = 0.
  - Both counters = 0.
- Reset mid-operation returns to IDLE immediately, with no pulse emitted.
- Latency:
  - `init_done`↑ to first `draw_start` = 3 cycles (1 IDLE→SETTLE, 2 SETTLE).
  - `draw_done` to `next_char_flag` = 1 cycle.
  - `next_char_flag` to the next `draw_start` = 3 cycles.
- The `next_char_flag` and `frame_done` pulses are in the same cycle at the end of a frame.
- The GAP counter and the timeout counter clear on state entry. The timeout counter counts 1..`TIMEOUT_CYC` inclusive.

## Structure
- Shared package `lcd_pkg`:
  - The one-hot glyph codes (FIRST..XIAOSHU), shared with the character selector.
  - The scheduler state enum.
  - The default Y/height constants.
- One sub-module, `cycle_timer`: a loadable 32-bit down-counter with a `clear` input and an `expired` output. It is instantiated once and reused for both GAP and WAIT timeout, since the two states are exclusive.

## Test plan
- **Power-up.** Reset, `init_done`=1 at cycle 10, selector model `the_char`=FIRST, `window_x0`=20, `x_size`=31 → `draw_start` at cycle 13 with window (20,51,40,71), `select`=1.
- **Line switch.** `the_char`=XIAOSHU, `window_x0`=190, `x_size`=31, `draw_done` 5 cycles after start → `next_char_flag` 1 cycle later; `select`→0; next `win_y0`=100, `win_y1`=131.
- **Frame end.** XIAOSHU done with `select`=0 → `frame_done` and `next_char_flag` in the same cycle; `select`→1; no `draw_start` for `GAP_CYC` (set to 50 in the bench) + 3 cycles.
- **Timeout.** `TIMEOUT_CYC`=20, never assert `draw_done` → `err_timeout` set at cycle 20 of WAIT and stays sticky; `next_char_flag` follows 1 cycle later.
- **Ignored done.** `draw_done` pulsed in the START cycle → ignored; the scheduler stays in WAIT until a second pulse.
- **Init/reset.** `init_done`=0 during GAP → IDLE, `busy`=0. Async `rst_n` low mid-WAIT → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD readout path: glyph codes used by the
// character selector, the scheduler state encoding and default geometry.
package lcd_pkg;

    // One-hot glyph codes. XIAOSHU (decimal point) terminates every line.
    localparam logic [6:0] FIRST   = 7'b0000001;
    localparam logic [6:0] SECOND  = 7'b0000010;
    localparam logic [6:0] THIRD   = 7'b0000100;
    localparam logic [6:0] FOURTH  = 7'b0001000;
    localparam logic [6:0] FIFTH   = 7'b0010000;
    localparam logic [6:0] SIXTH   = 7'b0100000;
    localparam logic [6:0] XIAOSHU = 7'b1000000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_GAP     = 3'd5
    } sched_state_t;

    localparam logic [15:0] Y_TEMP_DEF      = 16'd40;
    localparam logic [15:0] Y_HUM_DEF       = 16'd100;
    localparam logic [15:0] CHAR_H_DEF      = 16'd32;
    localparam logic [31:0] GAP_CYC_DEF     = 32'd25_000_000;
    localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd1_000_000;

    // A state lasting n cycles loads n-1 so the timer hits zero in its last cycle.
    function automatic logic [31:0] timer_load(input logic [31:0] n);
        return (n == 32'd0) ? 32'd0 : n - 32'd1;
    endfunction

endpackage

// File: rtl/lcd_char_scheduler_if.sv
// Bundle between the scheduler, the character selector and the draw engine.
// Handshake: draw_start is a one-cycle pulse and the window is valid in that
// cycle and held until the next draw_start; draw_done is a one-cycle pulse
// back from the engine. next_char_flag is a one-cycle advance pulse to the
// selector, which answers with a new the_char next cycle and x_size a cycle
// later. There is no backpressure on any of these pulses.
interface lcd_char_scheduler_if;
    logic [6:0]  the_char;
    logic [15:0] window_x0;
    logic [5:0]  x_size;
    logic        next_char_flag;
    logic        select;
    logic        draw_start;
    logic        draw_done;
    logic [15:0] win_x0;
    logic [15:0] win_x1;
    logic [15:0] win_y0;
    logic [15:0] win_y1;

    modport master (
        input  the_char, window_x0, x_size, draw_done,
        output next_char_flag, select, draw_start,
        output win_x0, win_x1, win_y0, win_y1
    );

    modport slave (
        output the_char, window_x0, x_size, draw_done,
        input  next_char_flag, select, draw_start,
        input  win_x0, win_x1, win_y0, win_y1
    );
endinterface

// File: rtl/lcd_char_scheduler_cycle_timer.sv
// Loadable 32-bit down-counter shared by the refresh gap and draw timeout.
module cycle_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        expired
);

    logic [31:0] cnt_q;

    // Count down to zero and hold there; clear wins over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
        end
    end

    assign expired = (cnt_q == 32'd0);

endmodule

// File: rtl/lcd_char_scheduler.sv
// Paces the character selector one glyph at a time, hands each glyph window
// to the draw engine, alternates temperature/humidity lines and inserts a
// refresh gap between frames.
module lcd_char_scheduler
    import lcd_pkg::*;
#(
    parameter logic [15:0] Y_TEMP      = Y_TEMP_DEF,
    parameter logic [15:0] Y_HUM       = Y_HUM_DEF,
    parameter logic [15:0] CHAR_H      = CHAR_H_DEF,
    parameter logic [31:0] GAP_CYC     = GAP_CYC_DEF,
    parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    lcd_char_scheduler_if.master bus,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 err_timeout,
    output sched_state_t         state_dbg
);

    sched_state_t state_q, state_d;
    logic         settle_q;
    logic         select_q;
    logic         err_q;
    logic         is_last;
    logic         timeout_now;
    logic         timer_clear, timer_load_en, timer_expired;
    logic [31:0]  timer_val;
    logic [15:0]  wx0_q, wx1_q, wy0_q, wy1_q;
    logic [15:0]  y0_sel;

    assign is_last     = (bus.the_char == XIAOSHU);
    assign timeout_now = (state_q == S_WAIT) && !bus.draw_done && timer_expired;
    assign y0_sel      = select_q ? Y_TEMP : Y_HUM;

    // The timer is loaded on entry to WAIT (from START) or GAP (from ADVANCE).
    assign timer_clear   = (state_q == S_IDLE);
    assign timer_load_en = (state_q == S_START) ||
                           ((state_q == S_ADVANCE) && (state_d == S_GAP));
    assign timer_val     = (state_q == S_START) ? timer_load(TIMEOUT_CYC)
                                                : timer_load(GAP_CYC);

    cycle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .load     (timer_load_en),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; draw_done only matters in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (init_done) state_d = S_SETTLE;
            S_SETTLE: begin
                if (!init_done)    state_d = S_IDLE;
                else if (settle_q) state_d = S_START;
            end
            S_START:   state_d = S_WAIT;
            S_WAIT:    if (bus.draw_done || timer_expired) state_d = S_ADVANCE;
            S_ADVANCE: state_d = (is_last && !select_q) ? S_GAP : S_SETTLE;
            S_GAP: begin
                if (!init_done)         state_d = S_IDLE;
                else if (timer_expired) state_d = S_SETTLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Pulse and status outputs decoded from the current state.
    always_comb begin
        bus.draw_start     = (state_q == S_START);
        bus.next_char_flag = (state_q == S_ADVANCE);
        frame_done         = (state_q == S_ADVANCE) && is_last && !select_q;
        busy               = (state_q != S_IDLE);
    end

    // SETTLE lasts two cycles: this flag marks the second one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) settle_q <= 1'b0;
        else        settle_q <= (state_q == S_SETTLE) && !settle_q;
    end

    // Line select flips on every XIAOSHU; sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            if ((state_q == S_ADVANCE) && is_last) select_q <= ~select_q;
            if (timeout_now)                       err_q    <= 1'b1;
        end
    end

    // Capture the window on entry to START so it is valid with draw_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx0_q <= '0;
            wx1_q <= '0;
            wy0_q <= '0;
            wy1_q <= '0;
        end else if ((state_q == S_SETTLE) && (state_d == S_START)) begin
            wx0_q <= bus.window_x0;
            wx1_q <= bus.window_x0 + {10'd0, bus.x_size};
            wy0_q <= y0_sel;
            wy1_q <= y0_sel + CHAR_H - 16'd1;
        end
    end

    assign err_timeout = err_q | timeout_now;
    assign bus.select  = select_q;
    assign bus.win_x0  = wx0_q;
    assign bus.win_x1  = wx1_q;
    assign bus.win_y0  = wy0_q;
    assign bus.win_y1  = wy1_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_lcd_char_scheduler.sv
// Bench for lcd_char_scheduler: a selector/draw-engine model drives random
// glyphs and draw delays; expected pulses and windows come from the cycle
// latencies and window arithmetic of the scheduler's contract.
module tb_lcd_char_scheduler;
    import lcd_pkg::*;

    localparam int GAP     = 50;
    localparam int TMO     = 20;
    localparam int MAX_CYC = 30000;

    logic         clk;
    logic         rst_n;
    logic         init_done;
    logic         frame_done;
    logic         busy;
    logic         err_timeout;
    sched_state_t state_dbg;

    lcd_char_scheduler_if bus();

    lcd_char_scheduler #(
        .Y_TEMP      (16'd40),
        .Y_HUM       (16'd100),
        .CHAR_H      (16'd32),
        .GAP_CYC     (32'd50),
        .TIMEOUT_CYC (32'd20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .bus         (bus),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    int          cyc;
    int          exp_start, exp_flag, err_cyc, done_cyc, sel_upd_cyc;
    int          idle_start, idle_end, draw_idx, frames;
    int          rst_cyc, drop_cyc, raise_cyc;
    bit          err_exp, line_temp, rst_done;
    int          g_pos, g_len;
    logic [15:0] g_x0;
    logic [5:0]  g_xs;
    logic [63:0] exp_q[$];
    logic [63:0] hold_win;
    int          n_cmp = 0;
    int          n_err = 0;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Last glyph of a line is XIAOSHU; the others walk up from FIRST.
    function automatic logic [6:0] glyph_code(input int pos, input int len);
        logic [6:0] one;
        one = 7'd1;
        if (pos == len - 1) return 7'b1000000;
        return one << pos;
    endfunction

    function automatic bit model_is_last();
        return (g_pos == g_len - 1);
    endfunction

    function automatic logic [63:0] exp_window();
        logic [15:0] y0;
        y0 = line_temp ? 16'd40 : 16'd100;
        return {g_x0, g_x0 + {10'd0, g_xs}, y0, y0 + 16'd31};
    endfunction

    task automatic schedule_start(input int at);
        exp_start = at;
        exp_q.delete();
        exp_q.push_back(exp_window());
    endtask

    task automatic new_glyph();
        g_x0 = 16'($urandom_range(0, 65535));
        g_xs = 6'($urandom_range(0, 63));
    endtask

    // ---------------- driver tasks ----------------
    // Sampling phase (negedge): compare DUT against the model, then advance it.
    task automatic observe();
        int mode;
        int next_at;
        if (cyc == err_cyc) err_exp = 1'b1;
        if (cyc == exp_start && exp_q.size() > 0) hold_win = exp_q.pop_front();

        check("draw_start",     64'(bus.draw_start),     64'(cyc == exp_start));
        check("next_char_flag", 64'(bus.next_char_flag), 64'(cyc == exp_flag));
        check("frame_done",     64'(frame_done),
              64'(cyc == exp_flag && model_is_last() && !line_temp));
        check("err_timeout",    64'(err_timeout), 64'(err_exp));
        check("busy",           64'(busy), 64'(!(cyc >= idle_start && cyc <= idle_end)));
        check("state_idle",     64'(state_dbg == S_IDLE), 64'(cyc >= idle_start && cyc <= idle_end));
        check("select",         64'(bus.select), 64'(line_temp));
        check("window", {bus.win_x0, bus.win_x1, bus.win_y0, bus.win_y1}, hold_win);

        if (cyc == exp_start) begin
            draw_idx++;
            exp_start = -1;
            if (frames >= 3 && !rst_done)      mode = 3;
            else if (draw_idx == 2)            mode = 1;
            else if (draw_idx == 4)            mode = 2;
            else begin
                mode = int'($urandom_range(0, 9));
                mode = (mode == 0) ? 2 : (mode <= 2) ? 1 : 0;
            end
            case (mode)
                0: begin
                    done_cyc = cyc + int'($urandom_range(1, 6));
                    exp_flag = done_cyc + 1;
                end
                1: begin
                    // Spurious done inside the START cycle must be ignored.
                    bus.draw_done = 1'b1;
                    done_cyc = cyc + int'($urandom_range(2, 6));
                    exp_flag = done_cyc + 1;
                end
                2: begin
                    done_cyc = -1;
                    exp_flag = cyc + TMO + 1;
                    err_cyc  = cyc + TMO;
                end
                default: begin
                    done_cyc = -1;
                    exp_flag = -1;
                    rst_cyc  = cyc + 5;
                end
            endcase
        end else if (cyc == exp_flag) begin
            if (model_is_last()) begin
                if (line_temp) begin
                    line_temp = 1'b0;
                    next_at   = cyc + 3;
                end else begin
                    line_temp = 1'b1;
                    frames++;
                    next_at   = cyc + GAP + 3;
                    if (frames == 2) begin
                        drop_cyc  = cyc + 10;
                        raise_cyc = cyc + 15;
                    end
                end
                g_pos = 0;
                g_len = int'($urandom_range(4, 5));
            end else begin
                g_pos++;
                next_at = cyc + 3;
            end
            new_glyph();
            sel_upd_cyc = cyc + 1;
            schedule_start(next_at);
            exp_flag = -1;
        end
    endtask

    // Drive phase (just after posedge): selector, draw engine, init and reset.
    task automatic drive();
        bus.draw_done = (cyc == done_cyc);
        if (cyc == sel_upd_cyc) begin
            bus.the_char  = glyph_code(g_pos, g_len);
            bus.window_x0 = g_x0;
            bus.x_size    = ~g_xs;  // selector's x_size lags the_char by a cycle
        end
        if (cyc == sel_upd_cyc + 1) bus.x_size = g_xs;
        if (cyc == 2)  rst_n = 1'b1;
        if (cyc == 10) init_done = 1'b1;
        if (cyc == drop_cyc) begin
            init_done  = 1'b0;
            exp_start  = -1;
            exp_q.delete();
            idle_start = cyc + 1;
            idle_end   = raise_cyc;
        end
        if (cyc == raise_cyc) begin
            init_done = 1'b1;
            schedule_start(cyc + 3);
        end
        if (cyc == rst_cyc) begin
            #2;
            rst_n      = 1'b0;
            line_temp  = 1'b1;
            err_exp    = 1'b0;
            err_cyc    = -1;
            hold_win   = '0;
            idle_start = cyc;
            idle_end   = cyc + 3;
            rst_done   = 1'b1;
        end
        if (cyc == rst_cyc + 3) begin
            rst_n = 1'b1;
            g_pos = 0;
            g_len = 7;
            new_glyph();
            bus.the_char  = glyph_code(g_pos, g_len);
            bus.window_x0 = g_x0;
            bus.x_size    = g_xs;
            schedule_start(cyc + 3);
        end
    endtask

    // ---------------- main sequence + final report ----------------
    initial begin
        rst_n         = 1'b0;
        init_done     = 1'b0;
        bus.draw_done = 1'b0;
        cyc         = 0;
        exp_start   = -1;
        exp_flag    = -1;
        err_cyc     = -1;
        done_cyc    = -1;
        sel_upd_cyc = -100;
        rst_cyc     = -100;
        drop_cyc    = -100;
        raise_cyc   = -100;
        draw_idx    = 0;
        frames      = 0;
        err_exp     = 1'b0;
        rst_done    = 1'b0;
        line_temp   = 1'b1;
        hold_win    = '0;
        idle_start  = 0;
        idle_end    = 10;
        g_pos       = 0;
        g_len       = 7;
        g_x0        = 16'd20;
        g_xs        = 6'd31;
        bus.the_char  = glyph_code(0, 7);
        bus.window_x0 = g_x0;
        bus.x_size    = g_xs;
        schedule_start(13);  // power-up window (20,51,40,71)

        @(posedge clk);
        #1;
        while (frames < 6 && cyc < MAX_CYC) begin
            @(negedge clk);
            observe();
            @(posedge clk);
            #1;
            cyc++;
            drive();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
